// File: rtl/axi_lite_avalon_sequencer.sv
// AXI4-Lite slave to Avalon-MM master sequencer.
// Serves one AXI-Lite transaction at a time on a single Avalon-MM master port.
// Reads and writes are arbitrated round-robin. Out-of-range addresses get SLVERR.
// A slave that stalls for C_TIMEOUT cycles is abandoned with SLVERR.
// All outputs are registered.
module axi_lite_avalon_sequencer #(
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR         = 32'h0000_FFFF,
    parameter int          C_AVS_ADDR_WIDTH   = 11,
    parameter int          C_TIMEOUT          = 255
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_AVS_ADDR_WIDTH-1:0]       avm_address,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   avm_byteenable,
    output logic                              avm_read,
    output logic                              avm_write,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     avm_writedata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     avm_readdata,
    input  logic                              avm_waitrequest
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int BW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [AW-1:0] BASE_ADDR = AW'(C_BASEADDR);
    localparam logic [AW-1:0] SPAN      = AW'(C_HIGHADDR - C_BASEADDR);
    localparam logic [7:0]    TMO_LIMIT = 8'(C_TIMEOUT);
    localparam logic [1:0]    RESP_OKAY = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_WR_RESP  = 3'd3,
        ST_RD_RESP  = 3'd4
    } state_t;

    // Offset compare avoids a constant-bound comparison when the base is zero.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        addr_in_range = ((addr - BASE_ADDR) <= SPAN);
    endfunction

    // Byte address relative to the window, converted to a truncated word address.
    function automatic logic [C_AVS_ADDR_WIDTH-1:0] word_addr(input logic [AW-1:0] addr);
        word_addr = C_AVS_ADDR_WIDTH'((addr - BASE_ADDR) >> 2'd2);
    endfunction

    state_t                    state_r, state_nx;
    logic                      last_rd_r, last_rd_nx;
    logic                      in_range_r, in_range_nx;
    logic [7:0]                tmo_cnt_r, tmo_cnt_nx;
    logic                      awready_r, awready_nx;
    logic                      wready_r, wready_nx;
    logic                      arready_r, arready_nx;
    logic                      bvalid_r, bvalid_nx;
    logic [1:0]                bresp_r, bresp_nx;
    logic                      rvalid_r, rvalid_nx;
    logic [1:0]                rresp_r, rresp_nx;
    logic [DW-1:0]             rdata_r, rdata_nx;
    logic [C_AVS_ADDR_WIDTH-1:0] avm_address_r, avm_address_nx;
    logic [BW-1:0]             avm_byteenable_r, avm_byteenable_nx;
    logic                      avm_read_r, avm_read_nx;
    logic                      avm_write_r, avm_write_nx;
    logic [DW-1:0]             avm_writedata_r, avm_writedata_nx;

    logic wr_cand_s;
    logic rd_cand_s;
    logic grant_wr_s;
    logic grant_rd_s;
    logic tmo_hit_s;

    // A write is only a candidate once both address and data are offered.
    assign wr_cand_s  = S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_cand_s  = S_AXI_ARVALID;
    assign grant_wr_s = wr_cand_s & (~rd_cand_s | last_rd_r);
    assign grant_rd_s = rd_cand_s & ~grant_wr_s;
    assign tmo_hit_s  = ((tmo_cnt_r + 8'd1) == TMO_LIMIT);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nx           = state_r;
        last_rd_nx         = last_rd_r;
        in_range_nx        = in_range_r;
        tmo_cnt_nx         = tmo_cnt_r;
        awready_nx         = 1'b0;
        wready_nx          = 1'b0;
        arready_nx         = 1'b0;
        bvalid_nx          = bvalid_r;
        bresp_nx           = bresp_r;
        rvalid_nx          = rvalid_r;
        rresp_nx           = rresp_r;
        rdata_nx           = rdata_r;
        avm_address_nx     = avm_address_r;
        avm_byteenable_nx  = avm_byteenable_r;
        avm_read_nx        = avm_read_r;
        avm_write_nx       = avm_write_r;
        avm_writedata_nx   = avm_writedata_r;

        case (state_r)
            ST_IDLE: begin
                avm_read_nx  = 1'b0;
                avm_write_nx = 1'b0;
                if (grant_wr_s) begin
                    state_nx          = ST_WR_ISSUE;
                    awready_nx        = 1'b1;
                    wready_nx         = 1'b1;
                    tmo_cnt_nx        = 8'd0;
                    in_range_nx       = addr_in_range(S_AXI_AWADDR);
                    avm_address_nx    = word_addr(S_AXI_AWADDR);
                    avm_byteenable_nx = S_AXI_WSTRB;
                    avm_writedata_nx  = S_AXI_WDATA;
                    avm_write_nx      = addr_in_range(S_AXI_AWADDR);
                end else if (grant_rd_s) begin
                    state_nx          = ST_RD_ISSUE;
                    arready_nx        = 1'b1;
                    tmo_cnt_nx        = 8'd0;
                    in_range_nx       = addr_in_range(S_AXI_ARADDR);
                    avm_address_nx    = word_addr(S_AXI_ARADDR);
                    avm_byteenable_nx = {BW{1'b1}};
                    avm_read_nx       = addr_in_range(S_AXI_ARADDR);
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_WR_ISSUE: begin
                if (!in_range_r) begin
                    state_nx     = ST_WR_RESP;
                    bvalid_nx    = 1'b1;
                    bresp_nx     = RESP_SLVERR;
                    avm_write_nx = 1'b0;
                end else if (!avm_waitrequest) begin
                    state_nx     = ST_WR_RESP;
                    bvalid_nx    = 1'b1;
                    bresp_nx     = RESP_OKAY;
                    avm_write_nx = 1'b0;
                end else if (tmo_hit_s) begin
                    state_nx     = ST_WR_RESP;
                    bvalid_nx    = 1'b1;
                    bresp_nx     = RESP_SLVERR;
                    avm_write_nx = 1'b0;
                end else begin
                    tmo_cnt_nx = tmo_cnt_r + 8'd1;
                end
            end

            ST_RD_ISSUE: begin
                if (!in_range_r) begin
                    state_nx    = ST_RD_RESP;
                    rvalid_nx   = 1'b1;
                    rresp_nx    = RESP_SLVERR;
                    rdata_nx    = {DW{1'b0}};
                    avm_read_nx = 1'b0;
                end else if (!avm_waitrequest) begin
                    state_nx    = ST_RD_RESP;
                    rvalid_nx   = 1'b1;
                    rresp_nx    = RESP_OKAY;
                    rdata_nx    = avm_readdata;
                    avm_read_nx = 1'b0;
                end else if (tmo_hit_s) begin
                    state_nx    = ST_RD_RESP;
                    rvalid_nx   = 1'b1;
                    rresp_nx    = RESP_SLVERR;
                    rdata_nx    = {DW{1'b0}};
                    avm_read_nx = 1'b0;
                end else begin
                    tmo_cnt_nx = tmo_cnt_r + 8'd1;
                end
            end

            ST_WR_RESP: begin
                avm_write_nx = 1'b0;
                if (S_AXI_BREADY) begin
                    state_nx   = ST_IDLE;
                    bvalid_nx  = 1'b0;
                    last_rd_nx = 1'b0;
                end else begin
                    state_nx = ST_WR_RESP;
                end
            end

            ST_RD_RESP: begin
                avm_read_nx = 1'b0;
                if (S_AXI_RREADY) begin
                    state_nx   = ST_IDLE;
                    rvalid_nx  = 1'b0;
                    last_rd_nx = 1'b1;
                end else begin
                    state_nx = ST_RD_RESP;
                end
            end

            default: begin
                state_nx     = ST_IDLE;
                avm_read_nx  = 1'b0;
                avm_write_nx = 1'b0;
                bvalid_nx    = 1'b0;
                rvalid_nx    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; the pointer starts as if a read was served last so writes win first.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r          <= ST_IDLE;
            last_rd_r        <= 1'b1;
            in_range_r       <= 1'b0;
            tmo_cnt_r        <= 8'd0;
            awready_r        <= 1'b0;
            wready_r         <= 1'b0;
            arready_r        <= 1'b0;
            bvalid_r         <= 1'b0;
            bresp_r          <= 2'b00;
            rvalid_r         <= 1'b0;
            rresp_r          <= 2'b00;
            rdata_r          <= {DW{1'b0}};
            avm_address_r    <= {C_AVS_ADDR_WIDTH{1'b0}};
            avm_byteenable_r <= {BW{1'b0}};
            avm_read_r       <= 1'b0;
            avm_write_r      <= 1'b0;
            avm_writedata_r  <= {DW{1'b0}};
        end else begin
            state_r          <= state_nx;
            last_rd_r        <= last_rd_nx;
            in_range_r       <= in_range_nx;
            tmo_cnt_r        <= tmo_cnt_nx;
            awready_r        <= awready_nx;
            wready_r         <= wready_nx;
            arready_r        <= arready_nx;
            bvalid_r         <= bvalid_nx;
            bresp_r          <= bresp_nx;
            rvalid_r         <= rvalid_nx;
            rresp_r          <= rresp_nx;
            rdata_r          <= rdata_nx;
            avm_address_r    <= avm_address_nx;
            avm_byteenable_r <= avm_byteenable_nx;
            avm_read_r       <= avm_read_nx;
            avm_write_r      <= avm_write_nx;
            avm_writedata_r  <= avm_writedata_nx;
        end
    end

    assign S_AXI_AWREADY  = awready_r;
    assign S_AXI_WREADY   = wready_r;
    assign S_AXI_ARREADY  = arready_r;
    assign S_AXI_BVALID   = bvalid_r;
    assign S_AXI_BRESP    = bresp_r;
    assign S_AXI_RVALID   = rvalid_r;
    assign S_AXI_RRESP    = rresp_r;
    assign S_AXI_RDATA    = rdata_r;
    assign avm_address    = avm_address_r;
    assign avm_byteenable = avm_byteenable_r;
    assign avm_read       = avm_read_r;
    assign avm_write      = avm_write_r;
    assign avm_writedata  = avm_writedata_r;

endmodule

// File: tb/tb_axi_lite_avalon_sequencer.sv
// Self-checking bench: randomized AXI-Lite traffic against a transaction-level reference model.
module tb_axi_lite_avalon_sequencer;

    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] HIGH = 32'h0000_FFFF;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [10:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    always #5 ACLK = ~ACLK;

    axi_lite_avalon_sequencer #(
        .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH),
        .C_AVS_ADDR_WIDTH(11), .C_TIMEOUT(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: which transaction type was served last (reset favours write).
    bit model_last_rd = 1'b1;

    // Slave model and observation records.
    int          slave_wait;
    logic [31:0] slave_rdata;
    int          strobe_run;
    int          wr_strobes, rd_strobes;
    logic [10:0] wr_addr_seen, rd_addr_seen;
    logic [3:0]  wr_be_seen, rd_be_seen;
    logic [31:0] wd_seen;
    int          aw_rdy_n, w_rdy_n, ar_rdy_n;
    int          first_grant;   // 0 none, 1 write, 2 read, 3 both at once

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: observe at the falling edge, then play the Avalon slave for the next rising edge.
    task automatic tick();
        @(negedge ACLK);
        if (avm_read || avm_write) begin
            check_eq("strobe_excl", 64'(avm_read & avm_write), 64'd0);
            strobe_run++;
            if (avm_write) begin
                wr_strobes++;
                if (wr_strobes == 1) begin
                    wr_addr_seen = avm_address; wr_be_seen = avm_byteenable; wd_seen = avm_writedata;
                end
            end
            if (avm_read) begin
                rd_strobes++;
                if (rd_strobes == 1) begin
                    rd_addr_seen = avm_address; rd_be_seen = avm_byteenable;
                end
            end
        end else begin
            strobe_run = 0;
        end
        avm_waitrequest = (avm_read || avm_write) && (strobe_run <= slave_wait);
        avm_readdata    = (avm_read && !avm_waitrequest) ? slave_rdata : $urandom();
        if (S_AXI_AWREADY) aw_rdy_n++;
        if (S_AXI_WREADY)  w_rdy_n++;
        if (S_AXI_ARREADY) ar_rdy_n++;
        if (first_grant == 0) begin
            if (S_AXI_AWREADY && S_AXI_ARREADY) first_grant = 3;
            else if (S_AXI_AWREADY)             first_grant = 1;
            else if (S_AXI_ARREADY)             first_grant = 2;
            else                                first_grant = 0;
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    // Offer a write, a read, or both at once; compare everything against the model.
    task automatic run(input bit do_wr, input bit do_rd,
                       input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] raddr, input logic [31:0] rdval,
                       input int nwait, input int bdel, input bit chk_lat);
        bit          w_in, r_in, b_done, r_done;
        int          exp_w_str, exp_r_str, exp_w_lat, exp_r_lat, exp_first;
        logic [1:0]  exp_bresp, exp_rresp;
        logic [31:0] exp_rdata;
        int          aw_k, ar_k, b_lat, r_lat, b_hold, r_hold;

        w_in      = in_win(waddr);
        r_in      = in_win(raddr);
        exp_w_str = w_in ? ((nwait < TO) ? nwait + 1 : TO) : 0;
        exp_r_str = r_in ? ((nwait < TO) ? nwait + 1 : TO) : 0;
        exp_w_lat = w_in ? ((nwait < TO) ? nwait + 2 : TO + 1) : 2;
        exp_r_lat = r_in ? ((nwait < TO) ? nwait + 2 : TO + 1) : 2;
        exp_bresp = (w_in && nwait < TO) ? 2'b00 : 2'b10;
        exp_rresp = (r_in && nwait < TO) ? 2'b00 : 2'b10;
        exp_rdata = (r_in && nwait < TO) ? rdval : 32'd0;
        exp_first = (do_wr && do_rd) ? (model_last_rd ? 1 : 2) : (do_wr ? 1 : 2);

        wr_strobes = 0; rd_strobes = 0; aw_rdy_n = 0; w_rdy_n = 0; ar_rdy_n = 0; first_grant = 0;
        slave_wait = nwait; slave_rdata = rdval;
        aw_k = -1; ar_k = -1; b_lat = -1; r_lat = -1; b_hold = 0; r_hold = 0;
        b_done = !do_wr; r_done = !do_rd;

        if (do_wr) begin
            S_AXI_AWADDR = waddr; S_AXI_WDATA = wdata; S_AXI_WSTRB = wstrb;
            S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        end
        if (do_rd) begin
            S_AXI_ARADDR = raddr; S_AXI_ARVALID = 1'b1;
        end

        for (int k = 1; k <= 100 && !(b_done && r_done); k++) begin
            tick();
            if (aw_k >= 0 && k == aw_k + 1) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
            if (ar_k >= 0 && k == ar_k + 1) S_AXI_ARVALID = 1'b0;
            if (S_AXI_AWREADY && aw_k < 0) aw_k = k;
            if (S_AXI_ARREADY && ar_k < 0) ar_k = k;
            if (!b_done) begin
                if (S_AXI_BVALID) begin
                    if (b_lat < 0) b_lat = k;
                    check_eq("bresp", 64'(S_AXI_BRESP), 64'(exp_bresp));
                    b_hold++;
                    if (b_hold > bdel) S_AXI_BREADY = 1'b1;
                end else if (S_AXI_BREADY) begin
                    b_done = 1'b1; S_AXI_BREADY = 1'b0;
                end
            end
            if (!r_done) begin
                if (S_AXI_RVALID) begin
                    if (r_lat < 0) r_lat = k;
                    check_eq("rresp", 64'(S_AXI_RRESP), 64'(exp_rresp));
                    check_eq("rdata", 64'(S_AXI_RDATA), 64'(exp_rdata));
                    r_hold++;
                    if (r_hold > bdel) S_AXI_RREADY = 1'b1;
                end else if (S_AXI_RREADY) begin
                    r_done = 1'b1; S_AXI_RREADY = 1'b0;
                end
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

        check_eq("txn_done", 64'({b_done, r_done}), 64'd3);
        check_eq("first_grant", 64'(first_grant), 64'(exp_first));
        if (do_wr) begin
            check_eq("aw_ready_pulses", 64'(aw_rdy_n), 64'd1);
            check_eq("w_ready_pulses", 64'(w_rdy_n), 64'd1);
            check_eq("wr_strobe_cycles", 64'(wr_strobes), 64'(exp_w_str));
            if (exp_w_str > 0) begin
                check_eq("wr_addr", 64'(wr_addr_seen), 64'(11'((waddr - BASE) >> 2)));
                check_eq("wr_be", 64'(wr_be_seen), 64'(wstrb));
                check_eq("wr_data", 64'(wd_seen), 64'(wdata));
            end
            if (chk_lat) check_eq("b_latency", 64'(b_lat), 64'(exp_w_lat));
        end
        if (do_rd) begin
            check_eq("ar_ready_pulses", 64'(ar_rdy_n), 64'd1);
            check_eq("rd_strobe_cycles", 64'(rd_strobes), 64'(exp_r_str));
            if (exp_r_str > 0) begin
                check_eq("rd_addr", 64'(rd_addr_seen), 64'(11'((raddr - BASE) >> 2)));
                check_eq("rd_be", 64'(rd_be_seen), 64'hF);
            end
            if (chk_lat) check_eq("r_latency", 64'(r_lat), 64'(exp_r_lat));
        end
        model_last_rd = (do_wr && do_rd) ? (exp_first == 1) : do_rd;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hs"}, 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                                    S_AXI_RVALID, avm_read, avm_write}), 64'd0);
        check_eq({tag, "_rdata"}, 64'(S_AXI_RDATA), 64'd0);
        check_eq({tag, "_resp"}, 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
        check_eq({tag, "_avm"}, {avm_address, avm_byteenable, avm_writedata}, 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return 32'($urandom_range(0, 32'h0000_FFFF));
        else if ($urandom_range(0, 1) == 0) return 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd4;
        else return 32'hFFFF_FFFC;
    endfunction

    initial begin
        int rv;
        ARESETN = 1'b0;
        S_AXI_AWADDR = 32'd0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 32'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; avm_readdata = 32'd0; avm_waitrequest = 1'b0;
        slave_wait = 0; slave_rdata = 32'd0; strobe_run = 0;
        repeat (3) tick();
        check_reset_outputs("reset");
        ARESETN = 1'b1;
        tick();

        // Directed cases.
        run(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 0, 0, 1'b1);
        run(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 32'hCAFEF00D, 3, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            run(1'b1, 1'b1, 32'h40 + 32'(i) * 32'd8, $urandom(), 4'(i + 3), 32'h44 + 32'(i) * 32'd8,
                $urandom(), 1, 0, 1'b0);
        run(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0001_0000, 32'h1234_5678, 0, 0, 1'b1);
        run(1'b1, 1'b0, 32'h0001_0000, 32'h5555_AAAA, 4'hF, 32'h0, 32'h0, 0, 0, 1'b1);
        run(1'b1, 1'b0, 32'h80, 32'h0BAD_F00D, 4'h3, 32'h0, 32'h0, 100, 0, 1'b1);
        run(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h84, 32'h7777_7777, 100, 0, 1'b1);
        run(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'hFFFC, 32'h3333_4444, TO - 1, 2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            rv = int'($urandom_range(0, 2));
            run(rv != 2, rv != 1, rand_addr(), $urandom(), 4'($urandom_range(0, 15)), rand_addr(),
                $urandom(), int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), rv != 0);
        end

        // Write response held off by BREADY, then reset in the middle of a stalled read.
        run(1'b1, 1'b0, 32'h100, 32'hA5A5_5A5A, 4'hF, 32'h0, 32'h0, 0, 5, 1'b1);
        wr_strobes = 0; rd_strobes = 0; aw_rdy_n = 0; w_rdy_n = 0; ar_rdy_n = 0; first_grant = 0;
        slave_wait = 100;
        S_AXI_ARADDR = 32'h20; S_AXI_ARVALID = 1'b1;
        tick();
        tick();
        S_AXI_ARVALID = 1'b0;
        tick();
        check_eq("pre_reset_read_strobe", 64'(avm_read), 64'd1);
        ARESETN = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        ARESETN = 1'b1;
        model_last_rd = 1'b1;
        rv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (S_AXI_RVALID || S_AXI_BVALID || avm_read || avm_write) rv++;
        end
        check_eq("no_resp_after_reset", 64'(rv), 64'd0);
        slave_wait = 0;
        run(1'b1, 1'b1, 32'h200, 32'h1111_2222, 4'hC, 32'h204, 32'h9999_0000, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
